// File: rtl/peridot_phy_rxd_fifo.sv
// UART 8N1 receiver with 3-sample majority voting feeding a show-ahead byte FIFO.
// Latency: a byte is at out_valid/out_data 1 clk after the stop-bit decision.
// Backpressure: out_ready stalls the FIFO; a byte arriving when the FIFO is full and not popping is dropped and overrun pulses.
module peridot_phy_rxd_fifo #(
   parameter int CLOCK_FREQUENCY = 100000000,
   parameter int UART_BAUDRATE   = 115200,
   parameter int FIFO_DEPTH_BITS = 4
) (
   input  logic                     clk,
   input  logic                     reset_n,
   input  logic                     rxd,
   input  logic                     out_ready,
   output logic                     out_valid,
   output logic [7:0]               out_data,
   output logic [FIFO_DEPTH_BITS:0] fifo_level,
   output logic                     framing_error,
   output logic                     overrun
);

   localparam int DIV_RAW = CLOCK_FREQUENCY / (UART_BAUDRATE * 8);
   localparam int DIV     = (DIV_RAW < 2) ? 2 : DIV_RAW;
   localparam int CW      = $clog2(DIV);
   localparam int PW      = FIFO_DEPTH_BITS;
   localparam int LW      = FIFO_DEPTH_BITS + 1;
   localparam int DEPTH   = 1 << FIFO_DEPTH_BITS;

   typedef enum logic [2:0] {IDLE, START, DATA, STOP, WAITHIGH} state_t;

   state_t          state;
   logic            rx_meta, rxs, rxs_prev;
   logic [CW-1:0]   cnt;
   logic [2:0]      tick_idx;
   logic [2:0]      bit_cnt;
   logic [7:0]      shreg;
   logic            smp3, smp4;
   logic            all_hi;

   logic            tick, start_edge, maj, decide, push_req, frame_bad;

   assign tick       = (cnt == CW'(DIV - 1));
   assign start_edge = (state == IDLE) && rxs_prev && !rxs;
   // Third vote is the live sample taken on tick 5 itself.
   assign maj        = (smp3 & smp4) | (smp3 & rxs) | (smp4 & rxs);
   assign decide     = tick && (tick_idx == 3'd5);
   assign push_req   = (state == STOP) && decide && maj;
   assign frame_bad  = (state == STOP) && decide && !maj;

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state         <= IDLE;
         rx_meta       <= 1'b1;
         rxs           <= 1'b1;
         rxs_prev      <= 1'b1;
         cnt           <= '0;
         tick_idx      <= '0;
         bit_cnt       <= '0;
         shreg         <= '0;
         smp3          <= 1'b0;
         smp4          <= 1'b0;
         all_hi        <= 1'b0;
         framing_error <= 1'b0;
      end else begin
         rx_meta       <= rxd;
         rxs           <= rx_meta;
         rxs_prev      <= rxs;
         framing_error <= frame_bad;

         if (start_edge) begin
            cnt      <= '0;
            tick_idx <= '0;
         end else if (tick) begin
            cnt      <= '0;
            tick_idx <= tick_idx + 3'd1;
         end else begin
            cnt      <= cnt + CW'(1);
         end

         if (tick && tick_idx == 3'd3) smp3 <= rxs;
         if (tick && tick_idx == 3'd4) smp4 <= rxs;

         case (state)
            IDLE: if (start_edge) state <= START;
            START: begin
               if (decide && maj) state <= IDLE;
               else if (tick && tick_idx == 3'd7) begin
                  state   <= DATA;
                  bit_cnt <= '0;
               end
            end
            DATA: begin
               if (decide) shreg <= {maj, shreg[7:1]};
               if (tick && tick_idx == 3'd7) begin
                  if (bit_cnt == 3'd7) state <= STOP;
                  bit_cnt <= bit_cnt + 3'd1;
               end
            end
            STOP: begin
               if (decide) begin
                  state  <= maj ? IDLE : WAITHIGH;
                  all_hi <= 1'b0;
               end
            end
            WAITHIGH: begin
               // Leave only after a whole tick period with the line high, so a held break reports once.
               if (tick) begin
                  if (all_hi && rxs) state <= IDLE;
                  all_hi <= 1'b1;
               end else if (!rxs) begin
                  all_hi <= 1'b0;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

   logic [7:0]    mem [DEPTH];
   logic [PW-1:0] wptr, rptr, rptr_nxt;
   logic [LW-1:0] level;
   logic          full, pop, push_ok;

   assign out_valid  = (level != '0);
   assign fifo_level = level;
   assign full       = (level == LW'(DEPTH));
   assign pop        = out_valid && out_ready;
   assign push_ok    = push_req && (!full || pop);
   assign rptr_nxt   = rptr + PW'(1);

   always_ff @(posedge clk) begin
      if (push_ok) mem[wptr] <= shreg;
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         wptr     <= '0;
         rptr     <= '0;
         level    <= '0;
         out_data <= '0;
         overrun  <= 1'b0;
      end else begin
         overrun <= push_req && full && !pop;
         if (push_ok) wptr <= wptr + PW'(1);
         if (pop)     rptr <= rptr_nxt;
         case ({push_ok, pop})
            2'b10:   level <= level + LW'(1);
            2'b01:   level <= level - LW'(1);
            default: level <= level;
         endcase
         // Head register: next stored entry, or the incoming byte when it becomes the only one.
         if (pop) begin
            if (level > LW'(1))  out_data <= mem[rptr_nxt];
            else if (push_ok)    out_data <= shreg;
         end else if (level == '0 && push_ok) begin
            out_data <= shreg;
         end
      end
   end

endmodule
